// File: rtl/decode_branch_unit.sv
// decode_branch_unit: decode stage at the consumer end of the fetch interface.
// Resolves control flow (JMP/BZ/CALL/RET/HALT) locally against a small return
// stack and hands ALU ops to execute over a registered valid/ready handshake.
// Fetch cannot be stalled directly, so back-pressure is applied by redirecting
// fetch to the pc it just presented (replay).
module decode_branch_unit #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4   // power of two, >= 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic [DATA_WIDTH-1:0] instr_in,
  input  logic                  flag_z,
  output logic                  branch_en,
  output logic [ADDR_WIDTH-1:0] branch_addr,
  output logic                  dec_valid,
  input  logic                  ex_ready,
  output logic [2:0]            dec_op,
  output logic [3:0]            dec_rd,
  output logic [7:0]            dec_imm,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic                  halted,
  output logic                  err_ovf,
  output logic                  err_unf,
  output logic                  err_ill
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t                state;
  logic [SP_W-1:0]       sp;
  logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];

  logic [3:0]            opc;
  logic [ADDR_WIDTH-1:0] target;
  logic [ADDR_WIDTH-1:0] ret_addr;
  logic [IDX_W-1:0]      push_idx;
  logic [IDX_W-1:0]      top_idx;
  logic                  stall;
  logic                  is_alu;
  logic                  full;
  logic                  empty;
  logic                  push;

  assign opc      = instr_in[15:12];
  assign target   = ADDR_WIDTH'(instr_in[7:0]);
  assign ret_addr = pc_in + 1'b1;              // wraps at 2^ADDR_WIDTH
  assign stall    = dec_valid && !ex_ready;
  assign is_alu   = (opc != 4'h0) && !opc[3];
  // sp counts 0..STACK_DEPTH, so its MSB alone marks a full stack
  assign full     = sp[SP_W-1];
  assign empty    = (sp == '0);
  assign push_idx = sp[IDX_W-1:0];
  assign top_idx  = IDX_W'(sp - 1'b1);
  assign push     = (state == RUN) && !stall && (opc == 4'hA) && !full;
  assign halted   = (state == HALT);

  // Redirect decision: reset, halt/stall replay, then per-opcode control flow
  always_comb begin
    branch_en   = 1'b0;
    branch_addr = pc_in;
    if (!reset) begin
      branch_en = 1'b0;
    end else if (state == HALT || stall) begin
      branch_en = 1'b1;
    end else begin
      unique case (opc)
        4'h8: begin branch_en = 1'b1;   branch_addr = target; end
        4'h9: begin branch_en = flag_z; branch_addr = target; end
        4'hA: begin branch_en = !full;  branch_addr = target; end
        4'hB: begin branch_en = !empty; branch_addr = stack[top_idx]; end
        4'hF: branch_en = 1'b1;
        default: ;
      endcase
    end
  end

  // Return stack storage; contents need no reset since sp gates every read
  always_ff @(posedge clk) begin
    if (push) stack[push_idx] <= ret_addr;
  end

  // State, stack pointer, decode output registers and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      sp        <= '0;
      dec_valid <= 1'b0;
      dec_op    <= '0;
      dec_rd    <= '0;
      dec_imm   <= '0;
      dec_pc    <= '0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      err_ill   <= 1'b0;
    end else if (state == HALT) begin
      // frozen, but an op already handed to execute may still be accepted
      if (ex_ready) dec_valid <= 1'b0;
    end else if (!stall) begin
      dec_valid <= is_alu;
      if (is_alu) begin
        dec_op  <= instr_in[14:12];
        dec_rd  <= instr_in[11:8];
        dec_imm <= instr_in[7:0];
        dec_pc  <= pc_in;
      end
      unique case (opc)
        4'hA: if (full) err_ovf <= 1'b1;
              else      sp <= sp + 1'b1;
        4'hB: if (empty) err_unf <= 1'b1;
              else       sp <= sp - 1'b1;
        4'hC, 4'hD, 4'hE: err_ill <= 1'b1;
        4'hF: state <= HALT;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_branch_unit.sv
// Directed bench for decode_branch_unit with hand-computed expectations.
module tb_decode_branch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  pc_in = '0;
  logic [15:0] instr_in = '0;
  logic        flag_z = 1'b0;
  logic        ex_ready = 1'b1;
  logic        branch_en;
  logic [7:0]  branch_addr;
  logic        dec_valid;
  logic [2:0]  dec_op;
  logic [3:0]  dec_rd;
  logic [7:0]  dec_imm;
  logic [7:0]  dec_pc;
  logic        halted, err_ovf, err_unf, err_ill;

  int n_chk = 0;
  int n_err = 0;

  decode_branch_unit dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .instr_in(instr_in),
    .flag_z(flag_z), .branch_en(branch_en), .branch_addr(branch_addr),
    .dec_valid(dec_valid), .ex_ready(ex_ready), .dec_op(dec_op),
    .dec_rd(dec_rd), .dec_imm(dec_imm), .dec_pc(dec_pc), .halted(halted),
    .err_ovf(err_ovf), .err_unf(err_unf), .err_ill(err_ill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // present a fetch pair mid-cycle, let combinational outputs settle
  task automatic put(input logic [7:0] pc, input logic [15:0] ins);
    pc_in = pc; instr_in = ins; #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0; #2; reset = 1'b1; #1;
  endtask

  initial begin
    // reset state
    #7;
    chk("rst_bren", branch_en, 0);
    chk("rst_valid", dec_valid, 0);
    chk("rst_flags", {halted, err_ovf, err_unf, err_ill}, 0);
    chk("rst_fields", {dec_op, dec_rd, dec_imm, dec_pc}, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // back-to-back ALU ops
    put(8'h00, 16'h1305); chk("alu0_bren", branch_en, 0);
    tick();
    chk("alu0_valid", dec_valid, 1);
    chk("alu0_fields", {dec_op, dec_rd, dec_imm, dec_pc}, {3'd1, 4'h3, 8'h05, 8'h00});
    put(8'h01, 16'h2A10); chk("alu1_bren", branch_en, 0);
    tick();
    chk("alu1_valid", dec_valid, 1);
    chk("alu1_fields", {dec_op, dec_rd, dec_imm, dec_pc}, {3'd2, 4'hA, 8'h10, 8'h01});
    put(8'h02, 16'h0000); chk("nop_bren", branch_en, 0);
    tick();
    chk("nop_valid", dec_valid, 0);

    // stall for three cycles, then accept
    put(8'h03, 16'h3123); tick();
    chk("st_valid", dec_valid, 1);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(8'h04, 16'h4456);
      chk("st_bren", branch_en, 1);
      chk("st_addr", branch_addr, 8'h04);
      tick();
      chk("st_hold", {dec_valid, dec_op, dec_imm, dec_pc}, {1'b1, 3'd3, 8'h23, 8'h03});
    end
    ex_ready = 1'b1;
    put(8'h04, 16'h4456); chk("st_rel_bren", branch_en, 0);
    tick();
    chk("st_rel_fields", {dec_valid, dec_op, dec_rd, dec_imm, dec_pc}, {1'b1, 3'd4, 4'h4, 8'h56, 8'h04});
    put(8'h05, 16'h0000); tick();
    chk("st_drain", dec_valid, 0);

    // CALL / RET pair, then RET on the now-empty stack
    put(8'h10, 16'hA040);
    chk("call_br", {branch_en, branch_addr}, {1'b1, 8'h40});
    tick();
    put(8'h40, 16'hB000);
    chk("ret_br", {branch_en, branch_addr}, {1'b1, 8'h11});
    tick();
    put(8'h11, 16'hB000);
    chk("ret_empty_bren", branch_en, 0);
    tick();
    chk("ret_empty_errs", {err_ovf, err_unf}, 2'b01);

    // five nested CALLs: fifth overflows
    do_reset();
    chk("rst2_errs", {err_ovf, err_unf, err_ill}, 0);
    for (int i = 0; i < 5; i++) begin
      put(8'h20 + 8'(i), 16'hA030);
      chk("ncall_bren", branch_en, (i < 4) ? 1 : 0);
      if (i < 4) chk("ncall_addr", branch_addr, 8'h30);
      tick();
    end
    chk("ovf_flag", {err_ovf, err_unf}, 2'b10);
    put(8'h30, 16'hB000);
    chk("nret0", {branch_en, branch_addr}, {1'b1, 8'h24});
    tick();
    put(8'h24, 16'hB000);
    chk("nret1", {branch_en, branch_addr}, {1'b1, 8'h23});
    tick();
    chk("ovf_sticky", err_ovf, 1);

    // RET on empty straight after reset
    do_reset();
    put(8'h50, 16'hB000);
    chk("unf_bren", branch_en, 0);
    tick();
    chk("unf_flag", {err_ovf, err_unf}, 2'b01);

    // BZ both ways, JMP and CALL at pc wrap boundary
    put(8'h60, 16'h9020); flag_z = 1'b0;
    chk("bz_nt", branch_en, 0);
    flag_z = 1'b1; #1;
    chk("bz_t", {branch_en, branch_addr}, {1'b1, 8'h20});
    tick(); flag_z = 1'b0;
    put(8'hFF, 16'h80FF);
    chk("jmp_ff", {branch_en, branch_addr}, {1'b1, 8'hFF});
    tick();
    put(8'hFF, 16'hA010);
    chk("call_ff", {branch_en, branch_addr}, {1'b1, 8'h10});
    tick();
    put(8'h10, 16'hB000);
    chk("ret_wrap", {branch_en, branch_addr}, {1'b1, 8'h00});
    tick();

    // illegal opcode acts as NOP
    put(8'h00, 16'hD123);
    chk("ill_bren", branch_en, 0);
    tick();
    chk("ill_flag", {err_ill, dec_valid}, 2'b10);

    // HALT freezes fetch until reset
    put(8'h05, 16'hF000);
    chk("halt_br", {branch_en, branch_addr}, {1'b1, 8'h05});
    tick();
    for (int i = 0; i < 3; i++) begin
      put(8'h05, 16'h1111);
      chk("halt_hold", {halted, branch_en, branch_addr, dec_valid}, {1'b1, 1'b1, 8'h05, 1'b0});
      tick();
    end
    #2; reset = 1'b0; #1;
    chk("halt_rst_out", {halted, branch_en, dec_valid, err_ovf, err_unf, err_ill}, 0);
    chk("halt_rst_fields", {dec_op, dec_rd, dec_imm, dec_pc}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/decode_branch_unit.md
Name: decode_branch_unit

Overview:
- Consumer end of the instruction fetch interface. Each cycle it takes the fetched pc/instr pair, decodes the 16-bit instruction, and drives branch_en/branch_addr back into the fetch stage.
- Resolves JMP/BZ/CALL/RET/HALT locally, with a 4-entry return stack.
- Forwards ALU instructions to the execute stage over a registered valid/ready handshake.
- Fetch has no stall input, so this block stalls it by branching to the current pc (replay).

Parameters:
- ADDR_WIDTH, 8, pc / branch address width
- DATA_WIDTH, 16, instruction width
- STACK_DEPTH, 4, return stack entries (power of two)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- pc_in  input  ADDR_WIDTH  pc of the current fetched instruction
- instr_in  input  DATA_WIDTH  current fetched instruction
- flag_z  input  1  zero flag from execute, sampled in the BZ decode cycle
- branch_en  output  1  combinational; redirect fetch PC at the next edge
- branch_addr  output  ADDR_WIDTH  combinational redirect target
- dec_valid  output  1  registered; decoded ALU op available
- ex_ready  input  1  execute accepts the op when dec_valid && ex_ready
- dec_op  output  3  registered opcode[14:12] for ALU ops 1..7
- dec_rd  output  4  registered instr[11:8]
- dec_imm  output  8  registered instr[7:0]
- dec_pc  output  ADDR_WIDTH  registered pc of the decoded op
- halted  output  1  high in HALT state
- err_ovf  output  1  sticky: CALL issued with stack full
- err_unf  output  1  sticky: RET issued with stack empty
- err_ill  output  1  sticky: opcode 0xC..0xE seen

Behaviour:
- Reset (reset=0, async):
  - State RUN; stack pointer 0.
  - dec_valid, dec_op, dec_rd, dec_imm, dec_pc, halted and all err flags = 0.
  - branch_en forced 0.
- Opcode = instr_in[15:12]:
  - 0x0 NOP
  - 0x1–0x7 ALU
  - 0x8 JMP
  - 0x9 BZ
  - 0xA CALL
  - 0xB RET
  - 0xC–0xE illegal (acts as NOP, sets err_ill)
  - 0xF HALT
- Target is instr_in[7:0]. Return address is pc_in+1 mod 2^ADDR_WIDTH, so 0xFF wraps to 0x00.
- Stall condition: dec_valid && !ex_ready.
  - branch_en=1, branch_addr=pc_in, so fetch reloads the same pc.
  - dec_* registers hold.
  - No stack change, no state change, no err flag update. This takes priority over decode.
- RUN, not stalled, decode per opcode:
  - ALU: at the edge, dec_valid<=1 and capture op/rd/imm/pc. branch_en=0.
  - JMP: branch_en=1, addr=target.
  - BZ: branch_en=flag_z, addr=target. Not taken → fall through.
  - CALL: if sp<STACK_DEPTH, push return address, sp+1, branch to target. If full, no push, no branch, err_ovf<=1.
  - RET: if sp>0, branch_en=1, addr=top entry, then pop (sp-1). If empty, no branch, err_unf<=1.
  - HALT: next state HALT; branch_en=1, addr=pc_in.
  - For any non-ALU opcode: dec_valid<=0 at the edge, unless dec_valid was already high and was accepted this cycle (it was not stalled), in which case it clears as well.
- Handshake: dec_valid falls the cycle after acceptance unless a new ALU op is decoded that same cycle, in which case dec_valid stays 1 and the new fields are loaded (back-to-back, throughput 1 op/cycle).
- HALT state:
  - branch_en=1, branch_addr=pc_in every cycle (fetch frozen); halted=1.
  - A pending dec_valid still completes its handshake.
  - Only reset exits HALT.
- Reset mid-operation: stack contents are discarded (sp=0), pending dec_valid is dropped, errors clear.
- The err_* flags are sticky until reset.
- No branch delay slot: a redirect at edge N means the target instruction is decoded in cycle N+1.

Test Plan:
- Reset, then instrs 0x1305 @pc 0x00 and 0x2A10 @0x01 with ex_ready=1 → dec_valid high for 2 consecutive cycles; dec_op=1, rd=3, imm=0x05, pc=0x00, then op=2, rd=0xA, imm=0x10, pc=0x01; branch_en=0 throughout.
- ALU op with ex_ready=0 for 3 cycles → branch_en=1, branch_addr=current pc_in each cycle; dec_* stable; on ex_ready=1 the next instruction decodes.
- CALL 0xA040 @pc 0x10, then RET 0xB000 @0x40 → branch to 0x40, then branch to 0x11; sp returns to 0.
- 5 nested CALLs starting from empty → first 4 branch; 5th: branch_en=0 and err_ovf=1. RET on empty after reset → branch_en=0 and err_unf=1.
- BZ 0x9020 with flag_z=0 → no branch; with flag_z=1 → branch_addr=0x20. JMP 0x80FF @pc 0xFF → branch_addr=0xFF. CALL @pc 0xFF pushes 0x00.
- HALT 0xF000 @pc 0x05 → halted=1 and branch_en=1/addr=0x05 indefinitely; async reset low mid-HALT → all outputs 0 immediately.
